cond_logic_unit: RTL and testbench
==================================

// Module: cond_logic_unit
// PURPOSE
//  Consumer side of the ALU NZCV interface. Holds the architectural flag register ([3]=N [2]=Z [1]=C [0]=V),
//  updates it from ALU NZCV under FlagW, and evaluates each instruction's 4-bit condition code against the
//  stored flags. Registers the condition-gated PCSrc/RegWrite/MemWrite towards the datapath.
//  Sits between the control decoder/ALU and the register file, memory and PC logic.
// PARAMETERS
//  FLAG_RST   4'b0000  flag register value on reset
//  NV_ALWAYS  1        cond 4'b1111: 1 = always true, 0 = never true
// PORTS
//  clk       in   1  clock, all state on rising edge
//  rst_n     in   1  synchronous reset, active low
//  Stall     in   1  1 = hold all state (flags, outputs, shadow)
//  InValid   in   1  instruction present this cycle
//  Cond      in   4  instruction condition field
//  ALUFlags  in   4  NZCV from ALU, same cycle
//  FlagW     in   2  [1] update N,Z; [0] update C,V
//  PCS       in   1  instruction writes PC
//  RegW      in   1  instruction writes register file
//  MemW      in   1  instruction writes memory
//  NoWrite   in   1  compare-type op: suppress RegWrite
//  CondEx    out  1  combinational: Cond true vs current Flags, 0 when InValid=0
//  Flags     out  4  current flag register
//  OutValid  out  1  registered InValid
//  PCSrc     out  1  registered PCS & CondEx
//  RegWrite  out  1  registered RegW & ~NoWrite & CondEx
//  MemWrite  out  1  registered MemW & CondEx
// BEHAVIOUR
//  - One clock, synchronous active-low reset: rst_n=0 at edge -> Flags=FLAG_RST, OutValid=PCSrc=RegWrite=MemWrite=0.
//    Reset wins over Stall and any in-flight instruction; the in-flight instruction is dropped.
//  - Cond table: 0 Z,1 ~Z,2 C,3 ~C,4 N,5 ~N,6 V,7 ~V,8 C&~Z,9 ~C|Z,A N==V,B N!=V,C ~Z&(N==V),D Z|(N!=V),
//    E 1, F NV_ALWAYS. Evaluated against stored Flags only (no bypass from ALUFlags).
//  - Flag update at edge when InValid & CondEx & ~Stall: FlagW[1] -> Flags[3:2]<=ALUFlags[3:2];
//    FlagW[0] -> Flags[1:0]<=ALUFlags[1:0]. FlagW=00 or CondEx=0 -> Flags unchanged.
//  - Gated outputs: latency 1 cycle. When ~Stall: OutValid<=InValid; PCSrc/RegWrite/MemWrite <= gated terms
//    (all 0 when InValid=0). When Stall: every register holds; CondEx still combinational.
//  - Back-to-back: instruction k+1 sees flags written by instruction k (written at k's edge).
//  - Flag write and failed condition in same instruction: no update, no writes (whole instruction squashed).
// CONFIGURATION
//  - FLAG_SAVE_EN defined: adds ports SaveFlags(in,1), RestoreFlags(in,1) and 4-bit shadow register (reset FLAG_RST).
//    ~Stall & SaveFlags: shadow<=Flags (pre-update value). ~Stall & RestoreFlags: Flags<=shadow, overrides
//    the ALU update that cycle. Both together: swap (shadow<=old Flags, Flags<=old shadow). Independent of InValid.
//  - FLAG_SAVE_EN undefined: ports and shadow absent; behaviour otherwise identical.
// STRUCTURE
//  - Package cond_pkg: localparams for the 16 cond encodings, flag bit indices N_BIT=3,Z_BIT=2,C_BIT=1,V_BIT=0.
//  - Sub-module cond_check (combinational): Cond, Flags, NV_ALWAYS -> CondEx. Top holds registers and gating.
// TESTING
//  - Reset: rst_n=0 one edge with FLAG_RST=0 -> Flags=0000, OutValid=0, PCSrc=RegWrite=MemWrite=0.
//  - Cond=E, FlagW=11, ALUFlags=0100, RegW=1 -> next edge Flags=0100, RegWrite=1, OutValid=1; then Cond=0 RegW=1 -> CondEx=1, RegWrite=1.
//  - Flags=0100, Cond=1, FlagW=11, ALUFlags=1000, MemW=1 -> CondEx=0, Flags stay 0100, MemWrite=0, OutValid=1.
//  - Flags=0000, Cond=E, FlagW=10, ALUFlags=1111 -> Flags=1100; then FlagW=01, ALUFlags=0011 -> Flags=1111.
//  - Signed conds: Flags=1001 -> Cond A/C true, B false; Flags=1000 -> Cond B/D true; Cond=F with NV_ALWAYS=0 -> CondEx=0.
//  - Stall=1 with valid flag-writing instr -> Flags/outputs hold; rst_n=0 during Stall -> reset values; FLAG_SAVE_EN: save 1100, write 0011, restore -> Flags=1100.

Source files
------------

// File: rtl/cond_pkg.sv
// Package for the condition logic unit: condition-code encodings, flag bit
// positions and the masked flag-write helper shared by the top level.
package cond_pkg;

    // Condition-field encodings (ARM-style mnemonics)
    localparam logic [3:0] COND_EQ = 4'h0;  // Z
    localparam logic [3:0] COND_NE = 4'h1;  // ~Z
    localparam logic [3:0] COND_CS = 4'h2;  // C
    localparam logic [3:0] COND_CC = 4'h3;  // ~C
    localparam logic [3:0] COND_MI = 4'h4;  // N
    localparam logic [3:0] COND_PL = 4'h5;  // ~N
    localparam logic [3:0] COND_VS = 4'h6;  // V
    localparam logic [3:0] COND_VC = 4'h7;  // ~V
    localparam logic [3:0] COND_HI = 4'h8;  // C & ~Z
    localparam logic [3:0] COND_LS = 4'h9;  // ~C | Z
    localparam logic [3:0] COND_GE = 4'hA;  // N == V
    localparam logic [3:0] COND_LT = 4'hB;  // N != V
    localparam logic [3:0] COND_GT = 4'hC;  // ~Z & (N == V)
    localparam logic [3:0] COND_LE = 4'hD;  // Z | (N != V)
    localparam logic [3:0] COND_AL = 4'hE;  // always
    localparam logic [3:0] COND_NV = 4'hF;  // configurable always/never

    // Bit positions inside the NZCV flag register
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // Merge ALU flags into the current flags under the two write-enable groups:
    // flag_w[1] covers N,Z and flag_w[0] covers C,V.
    function automatic logic [3:0] apply_flag_write(
        input logic [3:0] cur_flags,
        input logic [3:0] alu_flags,
        input logic [1:0] flag_w
    );
        logic [3:0] res;
        res = cur_flags;
        if (flag_w[1]) begin
            res[N_BIT] = alu_flags[N_BIT];
            res[Z_BIT] = alu_flags[Z_BIT];
        end
        if (flag_w[0]) begin
            res[C_BIT] = alu_flags[C_BIT];
            res[V_BIT] = alu_flags[V_BIT];
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether a 4-bit condition field
// holds for a given NZCV flag value. NV_ALWAYS selects whether the 4'hF
// encoding means "always" (1) or "never" (0).
module cond_check #(
    parameter logic NV_ALWAYS = 1'b1
) (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);
    import cond_pkg::*;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags_i[N_BIT];
    assign flag_z = flags_i[Z_BIT];
    assign flag_c = flags_i[C_BIT];
    assign flag_v = flags_i[V_BIT];

    // Decode the condition field against the supplied flags
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = flag_z;
            COND_NE: cond_ex_o = ~flag_z;
            COND_CS: cond_ex_o = flag_c;
            COND_CC: cond_ex_o = ~flag_c;
            COND_MI: cond_ex_o = flag_n;
            COND_PL: cond_ex_o = ~flag_n;
            COND_VS: cond_ex_o = flag_v;
            COND_VC: cond_ex_o = ~flag_v;
            COND_HI: cond_ex_o = flag_c & ~flag_z;
            COND_LS: cond_ex_o = ~flag_c | flag_z;
            COND_GE: cond_ex_o = (flag_n == flag_v);
            COND_LT: cond_ex_o = (flag_n != flag_v);
            COND_GT: cond_ex_o = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_ex_o = flag_z | (flag_n != flag_v);
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: cond_ex_o = NV_ALWAYS;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic_unit.sv
// Condition logic unit: owns the architectural NZCV flag register, updates it
// from the ALU under FlagW when the instruction's condition passes, and
// registers the condition-gated PCSrc/RegWrite/MemWrite towards the datapath.
// Optional feature macro: FLAG_SAVE_EN adds SaveFlags/RestoreFlags ports and a
// 4-bit shadow flag register (save, restore, or swap when both are asserted).
module cond_logic_unit #(
    parameter logic [3:0] FLAG_RST  = 4'b0000,
    parameter logic       NV_ALWAYS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef FLAG_SAVE_EN
    input  logic       SaveFlags,
    input  logic       RestoreFlags,
`endif
    input  logic       Stall,
    input  logic       InValid,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       CondEx,
    output logic [3:0] Flags,
    output logic       OutValid,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite
);
    import cond_pkg::*;

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       out_valid_q;
    logic       out_valid_d;
    logic       pc_src_q;
    logic       pc_src_d;
    logic       reg_write_q;
    logic       reg_write_d;
    logic       mem_write_q;
    logic       mem_write_d;
    logic       cond_true;

`ifdef FLAG_SAVE_EN
    logic [3:0] shadow_q;
    logic [3:0] shadow_d;
`endif

    // Condition is judged against the stored flags only; the same-cycle ALU
    // result is never bypassed into the decision.
    cond_check #(
        .NV_ALWAYS (NV_ALWAYS)
    ) u_cond_check (
        .cond_i    (Cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_true)
    );

    assign CondEx = InValid & cond_true;

    // Next-state: flag merge for passing instructions, shadow save/restore, gated write enables
    always_comb begin
        flags_d = flags_q;
        if (CondEx) begin
            flags_d = apply_flag_write(flags_q, ALUFlags, FlagW);
        end
`ifdef FLAG_SAVE_EN
        // Save captures the pre-update flags; restore overrides any ALU update.
        // Asserting both swaps the two registers.
        shadow_d = shadow_q;
        if (SaveFlags) begin
            shadow_d = flags_q;
        end
        if (RestoreFlags) begin
            flags_d = shadow_q;
        end
`endif
        // A failed condition squashes the whole instruction, including its writes
        out_valid_d = InValid;
        pc_src_d    = PCS & CondEx;
        reg_write_d = RegW & ~NoWrite & CondEx;
        mem_write_d = MemW & CondEx;
    end

    // State registers: synchronous reset dominates, Stall freezes everything else
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all registers update together at the edge.
        if (!rst_n) begin
            flags_q     <= FLAG_RST;
            out_valid_q <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef FLAG_SAVE_EN
            shadow_q    <= FLAG_RST;
`endif
        end else if (!Stall) begin
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            pc_src_q    <= pc_src_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
`ifdef FLAG_SAVE_EN
            shadow_q    <= shadow_d;
`endif
        end
    end

    assign Flags    = flags_q;
    assign OutValid = out_valid_q;
    assign PCSrc    = pc_src_q;
    assign RegWrite = reg_write_q;
    assign MemWrite = mem_write_q;

endmodule

// File: tb/tb_cond_logic_unit.sv
// Self-checking bench for cond_logic_unit. Two instances share the stimulus:
// dut uses NV_ALWAYS=1, dut_nv uses NV_ALWAYS=0. A behavioural model tracks
// both and is compared on every falling edge; directed steps add literal checks.
// Define FLAG_SAVE_EN to also exercise the shadow flag register.
module tb_cond_logic_unit;

    logic       clk;
    logic       rst_n;
    logic       Stall;
    logic       InValid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
`ifdef FLAG_SAVE_EN
    logic       SaveFlags;
    logic       RestoreFlags;
`endif

    logic       CondEx,  CondEx2;
    logic [3:0] Flags,   Flags2;
    logic       OutValid, OutValid2;
    logic       PCSrc,   PCSrc2;
    logic       RegWrite, RegWrite2;
    logic       MemWrite, MemWrite2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    cond_logic_unit #(.FLAG_RST(4'b0000), .NV_ALWAYS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef FLAG_SAVE_EN
        .SaveFlags(SaveFlags), .RestoreFlags(RestoreFlags),
`endif
        .Stall(Stall), .InValid(InValid), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .CondEx(CondEx), .Flags(Flags), .OutValid(OutValid), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite)
    );

    cond_logic_unit #(.FLAG_RST(4'b0000), .NV_ALWAYS(1'b0)) dut_nv (
        .clk(clk), .rst_n(rst_n),
`ifdef FLAG_SAVE_EN
        .SaveFlags(SaveFlags), .RestoreFlags(RestoreFlags),
`endif
        .Stall(Stall), .InValid(InValid), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .CondEx(CondEx2), .Flags(Flags2), .OutValid(OutValid2), .PCSrc(PCSrc2),
        .RegWrite(RegWrite2), .MemWrite(MemWrite2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Condition truth from the flag rules: codes 0..D come in pairs where the
    // odd code is the negation of the even one; E always, F configurable.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f, input logic nv);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return nv;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    // Model state, index 0 = dut (NV always), 1 = dut_nv (NV never)
    logic [3:0] m_flags [2];
    logic [3:0] m_shadow[2];
    logic       m_ov[2], m_pc[2], m_rw[2], m_mw[2];

    always @(posedge clk) begin : model_upd
        logic       ce;
        logic [3:0] nf;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_flags[i] = 4'b0000; m_shadow[i] = 4'b0000;
                m_ov[i] = 1'b0; m_pc[i] = 1'b0; m_rw[i] = 1'b0; m_mw[i] = 1'b0;
            end else if (!Stall) begin
                ce = InValid && cond_eval(Cond, m_flags[i], (i == 0));
                nf = m_flags[i];
                if (ce && FlagW[1]) nf[3:2] = ALUFlags[3:2];
                if (ce && FlagW[0]) nf[1:0] = ALUFlags[1:0];
`ifdef FLAG_SAVE_EN
                if (RestoreFlags) nf = m_shadow[i];
                if (SaveFlags) m_shadow[i] = m_flags[i];
`endif
                m_ov[i] = InValid;
                m_pc[i] = PCS && ce;
                m_rw[i] = RegW && !NoWrite && ce;
                m_mw[i] = MemW && ce;
                m_flags[i] = nf;
            end
        end
    end

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("condex",    {3'b0, CondEx},   {3'b0, InValid && cond_eval(Cond, m_flags[0], 1'b1)});
            check("flags",     Flags,            m_flags[0]);
            check("outvalid",  {3'b0, OutValid}, {3'b0, m_ov[0]});
            check("pcsrc",     {3'b0, PCSrc},    {3'b0, m_pc[0]});
            check("regwrite",  {3'b0, RegWrite}, {3'b0, m_rw[0]});
            check("memwrite",  {3'b0, MemWrite}, {3'b0, m_mw[0]});
            check("nv_condex", {3'b0, CondEx2},  {3'b0, InValid && cond_eval(Cond, m_flags[1], 1'b0)});
            check("nv_flags",  Flags2,           m_flags[1]);
            check("nv_regwr",  {3'b0, RegWrite2},{3'b0, m_rw[1]});
            check("nv_pcsrc",  {3'b0, PCSrc2},   {3'b0, m_pc[1]});
            check("nv_memwr",  {3'b0, MemWrite2},{3'b0, m_mw[1]});
            check("nv_outval", {3'b0, OutValid2},{3'b0, m_ov[1]});
        end
    end

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] alu, input logic pcs, input logic rw,
                         input logic mw, input logic nw);
        InValid = v; Cond = c; FlagW = fw; ALUFlags = alu;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; Stall = 1'b0;
`ifdef FLAG_SAVE_EN
        SaveFlags = 1'b0; RestoreFlags = 1'b0;
`endif
        drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_en = 1'b1;
        check("rst_flags", Flags, 4'b0000);
        check("rst_ov",  {3'b0, OutValid}, 4'd0);
        check("rst_pc",  {3'b0, PCSrc},    4'd0);
        check("rst_rw",  {3'b0, RegWrite}, 4'd0);
        check("rst_mw",  {3'b0, MemWrite}, 4'd0);
        rst_n = 1'b1;

        // Unconditional flag write with register write
        drive(1'b1, 4'hE, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("al_flags", Flags, 4'b0100);
        check("al_rw", {3'b0, RegWrite}, 4'd1);
        check("al_ov", {3'b0, OutValid}, 4'd1);

        // EQ sees the Z just written by the previous instruction
        drive(1'b1, 4'h0, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("eq_condex", {3'b0, CondEx}, 4'd1);
        tick();
        check("eq_rw", {3'b0, RegWrite}, 4'd1);

        // NE fails: flag write and memory write are both squashed
        drive(1'b1, 4'h1, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 check("ne_condex", {3'b0, CondEx}, 4'd0);
        tick();
        check("ne_flags", Flags, 4'b0100);
        check("ne_mw", {3'b0, MemWrite}, 4'd0);
        check("ne_ov", {3'b0, OutValid}, 4'd1);

        // Partial flag writes
        drive(1'b1, 4'hE, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'hE, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("fw10_flags", Flags, 4'b1100);
        drive(1'b1, 4'hE, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("fw01_flags", Flags, 4'b1111);

        // Signed conditions
        drive(1'b1, 4'hE, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'hA, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("ge_1001", {3'b0, CondEx}, 4'd1);
        Cond = 4'hC;
        #1 check("gt_1001", {3'b0, CondEx}, 4'd1);
        Cond = 4'hB;
        #1 check("lt_1001", {3'b0, CondEx}, 4'd0);
        drive(1'b1, 4'hE, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'hB, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("lt_1000", {3'b0, CondEx}, 4'd1);
        Cond = 4'hD;
        #1 check("le_1000", {3'b0, CondEx}, 4'd1);
        Cond = 4'hF;
        #1 check("nv_always", {3'b0, CondEx},  4'd1);
        check("nv_never",  {3'b0, CondEx2}, 4'd0);

        // Compare-type op suppresses RegWrite; PCS passes through
        drive(1'b1, 4'hE, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("nowrite_rw", {3'b0, RegWrite}, 4'd0);
        check("pcs_pc", {3'b0, PCSrc}, 4'd1);

        // No instruction: no CondEx, no flag update, no writes
        drive(1'b0, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 check("inv_condex", {3'b0, CondEx}, 4'd0);
        tick();
        check("inv_ov", {3'b0, OutValid}, 4'd0);
        check("inv_flags", Flags, 4'b1000);
        check("inv_pc", {3'b0, PCSrc}, 4'd0);

        // Stall holds flags and outputs; reset wins over stall
        drive(1'b1, 4'hE, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        Stall = 1'b1;
        drive(1'b1, 4'hE, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("stall_condex", {3'b0, CondEx}, 4'd1);
        tick();
        check("stall_flags", Flags, 4'b1000);
        check("stall_ov", {3'b0, OutValid}, 4'd1);
        check("stall_rw", {3'b0, RegWrite}, 4'd1);
        rst_n = 1'b0;
        tick();
        check("stallrst_flags", Flags, 4'b0000);
        check("stallrst_ov", {3'b0, OutValid}, 4'd0);
        check("stallrst_rw", {3'b0, RegWrite}, 4'd0);
        rst_n = 1'b1;
        Stall = 1'b0;

        // Every condition code against every flag value (model compares)
        for (int f = 0; f < 16; f++) begin
            drive(1'b1, 4'hE, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, 4'(c), 2'b00, 4'h0, c[0], 1'b1, c[1], c[2] & c[3]);
                tick();
            end
        end

`ifdef FLAG_SAVE_EN
        // Save, overwrite, restore
        drive(1'b1, 4'hE, 2'b11, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'hE, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        SaveFlags = 1'b1;
        tick();
        SaveFlags = 1'b0;
        drive(1'b1, 4'hE, 2'b11, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("save_wr", Flags, 4'b0011);
        drive(1'b0, 4'hE, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        RestoreFlags = 1'b1;
        tick();
        RestoreFlags = 1'b0;
        check("restore", Flags, 4'b1100);
        // Swap: flags 0101 <-> shadow 1100
        drive(1'b1, 4'hE, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'hE, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        SaveFlags = 1'b1; RestoreFlags = 1'b1;
        tick();
        SaveFlags = 1'b0;
        check("swap_flags", Flags, 4'b1100);
        // Restore overrides a simultaneous ALU update
        drive(1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        RestoreFlags = 1'b0;
        check("restore_ovr", Flags, 4'b0101);
`endif

        drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
